lsu_byte_serial: RTL and testbench
==================================

# lsu_byte_serial

Load/store unit that issues CPU data accesses to the byte-wide data memory port. It accepts one byte, halfword or word request at a time over a valid/ready handshake and serialises it into little-endian single-byte memory cycles. For loads it assembles the bytes and sign- or zero-extends the result. It returns one completion pulse per request, for loads and stores alike.

## Interface
Parameters:
- WIDTH, 32, address and CPU data width
- DATA_WIDTH, 8, memory port data width (one byte)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  WIDTH  byte address of the least-significant byte
- req_wdata  in  WIDTH  store data; low 8/16/32 bits are used
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  WIDTH  load result; 0 for stores; held until next completion
- busy  out  1  a transfer is in progress
- mem_addr  out  WIDTH  memory byte address
- mem_we  out  1  memory write enable, written on the clock edge
- mem_wd  out  DATA_WIDTH  memory write byte
- mem_rd  in  DATA_WIDTH  memory read byte, combinational from mem_addr in the same cycle

## Operation
- FSM states: IDLE, XFER, DONE.
- IDLE:
  - req_ready=1, busy=0, mem_we=0, mem_addr=0, mem_wd=0.
  - A handshake occurs when req_valid & req_ready. On that edge the unit latches we, size, unsigned, addr and wdata, clears the byte counter k and the assembly buffer, and enters XFER.
- XFER:
  - req_ready=0, busy=1.
  - N is 1, 2 or 4 from the latched size.
  - mem_addr = latched addr + k, modulo 2^WIDTH, so addresses wrap from all-ones to 0.
  - Store: mem_we=1 and mem_wd = wdata[8k+7:8k].
  - Load: mem_we=0 and mem_wd=0; on the edge, mem_rd is captured into buffer byte k.
  - k increments on every edge. The FSM leaves XFER after the edge with k = N-1.
- DONE:
  - busy=1, req_ready=0, mem_we=0.
  - rsp_valid=1 for exactly this cycle.
  - rsp_rdata is registered on entry to DONE:
    - byte: buffer[7:0] extended from bit 7.
    - half: buffer[15:0] extended from bit 15.
    - word: buffer, unchanged.
    - Extension fills upper bits with the sign bit when unsigned=0, zeros when unsigned=1.
    - Store: rsp_rdata = 0.
  - Next state is always IDLE. A request is never accepted in DONE.
- Inputs req_* are ignored outside the IDLE handshake. Changes to them after acceptance have no effect.
- Misaligned addresses are legal; there is no alignment fault.
- The byte counter is 2 bits wide. size 11 behaves exactly as size 10.

## Timing
- Reset: on the edge with rst=1, state becomes IDLE, k=0, buffer=0, rsp_rdata=0.
  - In the cycle after reset: req_ready=1, rsp_valid=0, busy=0, mem_we=0, mem_addr=0, mem_wd=0.
- Latency, with handshake on edge E0:
  - Byte j is accessed in cycle j+1 after E0.
  - rsp_valid is high in cycle N+1.
  - req_ready is high again in cycle N+2.
  - Throughput: one request per N+2 cycles.
- Reset mid-operation: rst takes priority in every state and the FSM returns to IDLE.
  - mem_we is 0 from the cycle after the reset edge.
  - Store bytes already written stay written; no rollback.
  - No rsp_valid is issued for the aborted request.
- rst and req_valid high together: reset wins and the request is not accepted.
- mem_* outputs are combinational from state, k and the latched request; there is no extra register stage.

## Test plan
- Word load, addr 0x10000, memory bytes 11 22 33 44:
  - mem_addr steps 0x10000..0x10003.
  - rsp_valid high in cycle 5 after the handshake.
  - rsp_rdata = 0x44332211.
- Signed byte load, addr 0x10005 holding 0x80 -> rsp_rdata = 0xFFFFFF80.
- Same byte load with req_unsigned=1 -> rsp_rdata = 0x00000080.
- Halfword load of bytes F0 FF, signed -> 0xFFFFFFF0; unsigned -> 0x0000FFF0.
- Word store, req_wdata 0xDEADBEEF, addr 0x10101 (misaligned):
  - mem_we high for 4 cycles, writing EF BE AD DE to 0x10101..0x10104.
  - Then rsp_valid=1 with rsp_rdata=0.
- Address wrap: half store at 0xFFFFFFFF -> bytes written to 0xFFFFFFFF then 0x00000000.
- Reset mid-operation: rst asserted in the second XFER cycle of a word store.
  - Only 2 bytes are written.
  - mem_we=0 and req_ready=1 in the cycle after the reset edge.
  - No rsp_valid is seen.
  - A following byte load completes normally.

Source files
------------

// File: rtl/lsu_byte_serial.sv
// Byte-serial load/store unit: splits byte/half/word CPU accesses into
// little-endian single-byte memory cycles and assembles/extends load data.
module lsu_byte_serial #(
  parameter int WIDTH      = 32,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [WIDTH-1:0]      req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  busy,
  output logic [WIDTH-1:0]      mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  localparam int OFS_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t           r_state;
  logic [1:0]       r_k;
  logic [WIDTH-1:0] r_buf;
  logic [WIDTH-1:0] r_rdata;
  logic             r_we;
  logic [1:0]       r_size;
  logic             r_unsigned;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;

  logic [OFS_W-1:0] w_ofs;
  logic [1:0]       w_last_k;
  logic [WIDTH-1:0] w_asm;
  logic [WIDTH-1:0] w_ext;
  logic             w_sign;

  // Bit offset of the byte currently being transferred.
  assign w_ofs = OFS_W'(r_k) << $clog2(DATA_WIDTH);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_last_k = 2'd3;
    case (r_size)
      2'b00:   w_last_k = 2'd0;
      2'b01:   w_last_k = 2'd1;
      default: w_last_k = 2'd3;
    endcase
  end

  // Buffer as it will look after this edge's capture, so the final byte
  // is included when rsp_rdata is registered on the transition to DONE.
  always_comb begin
    w_asm = r_buf;
    w_asm[w_ofs +: DATA_WIDTH] = mem_rd;
  end

  always_comb begin
    w_sign = 1'b0;
    w_ext  = w_asm;
    case (r_size)
      2'b00: begin
        w_sign = ~r_unsigned & w_asm[7];
        w_ext  = {{(WIDTH-8){w_sign}}, w_asm[7:0]};
      end
      2'b01: begin
        w_sign = ~r_unsigned & w_asm[15];
        w_ext  = {{(WIDTH-16){w_sign}}, w_asm[15:0]};
      end
      default: w_ext = w_asm;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_k        <= 2'd0;
      r_buf      <= '0;
      r_rdata    <= '0;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_k        <= 2'd0;
            r_buf      <= '0;
            r_state    <= XFER;
          end
        end
        XFER: begin
          if (!r_we) r_buf <= w_asm;
          r_k <= r_k + 2'd1;
          if (r_k == w_last_k) begin
            r_rdata <= r_we ? '0 : w_ext;
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign rsp_valid = (r_state == DONE);
  assign rsp_rdata = r_rdata;

  // Memory port is driven straight from state and the latched request.
  assign mem_addr = (r_state == XFER) ? r_addr + WIDTH'(r_k) : '0;
  assign mem_we   = (r_state == XFER) & r_we;
  assign mem_wd   = (r_state == XFER && r_we) ? r_wdata[w_ofs +: DATA_WIDTH] : '0;

endmodule

// File: tb/tb_lsu_byte_serial.sv
// Directed bench for lsu_byte_serial: byte-wide memory model, per-cycle port
// checks and a scoreboard queue of expected load/store results.
module tb_lsu_byte_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wd;
  logic [7:0]  mem_rd;

  int errors = 0;
  int checks = 0;
  int rsp_seen = 0;
  int wr_seen = 0;
  int n_req = 0;
  logic [31:0] sb_q[$];

  // 4 KiB memory aliased on the low address bits; preloaded while rst is high.
  logic [7:0] mem [0:4095];

  lsu_byte_serial #(.WIDTH(32), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_addr[11:0]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
      mem[12'h000] <= 8'h11;
      mem[12'h001] <= 8'h22;
      mem[12'h002] <= 8'h33;
      mem[12'h003] <= 8'h44;
      mem[12'h005] <= 8'h80;
      mem[12'h008] <= 8'hF0;
      mem[12'h009] <= 8'hFF;
    end else if (mem_we) begin
      mem[mem_addr[11:0]] <= mem_wd;
    end
  end

  always @(negedge clk) begin
    if (rsp_valid) rsp_seen++;
    if (mem_we) wr_seen++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request: handshake at the edge after this negedge, then N XFER
  // cycles, DONE in cycle N+1 and ready again in cycle N+2.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp, input string name);
    int n;
    logic [31:0] got;
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    @(negedge clk);
    check({name, " ready_pre"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size;
    req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    sb_q.push_back(exp);
    n_req++;
    for (int c = 1; c <= n + 2; c++) begin
      @(negedge clk);
      if (c <= n) begin
        check($sformatf("%s addr%0d", name, c - 1), mem_addr, addr + 32'(c - 1));
        check($sformatf("%s we%0d", name, c - 1), {31'd0, mem_we}, {31'd0, we});
        check($sformatf("%s wd%0d", name, c - 1), {24'd0, mem_wd},
              we ? {24'd0, wdata[8*(c-1) +: 8]} : 32'd0);
        check($sformatf("%s busy%0d", name, c - 1), {30'd0, busy, req_ready}, 32'd2);
        check($sformatf("%s early_rsp%0d", name, c - 1), {31'd0, rsp_valid}, 32'd0);
      end else if (c == n + 1) begin
        check({name, " rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({name, " done_flags"}, {29'd0, busy, req_ready, mem_we}, 32'd4);
        if (rsp_valid && sb_q.size() > 0) begin
          got = sb_q.pop_front();
          check({name, " rdata"}, rsp_rdata, got);
        end
      end else begin
        check({name, " ready_post"}, {30'd0, req_ready, rsp_valid}, 32'd2);
        check({name, " rdata_hold"}, rsp_rdata, exp);
      end
      if (c == 1) begin
        // Post-acceptance changes must have no effect.
        req_valid = 1'b0; req_we = ~we; req_size = ~size;
        req_unsigned = ~uns; req_addr = $urandom; req_wdata = $urandom;
      end
    end
  endtask

  initial begin
    int wr0;
    int rsp0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset flags", {26'd0, req_ready, rsp_valid, busy, mem_we, 2'b00}, 32'h20);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset mem_wd", {24'd0, mem_wd}, 32'd0);
    check("reset rdata", rsp_rdata, 32'd0);

    do_req(1'b0, 2'b10, 1'b0, 32'h0001_0000, 32'h0, 32'h4433_2211, "ld_word");
    do_req(1'b0, 2'b00, 1'b0, 32'h0001_0005, 32'h0, 32'hFFFF_FF80, "ld_sbyte");
    do_req(1'b0, 2'b00, 1'b1, 32'h0001_0005, 32'h0, 32'h0000_0080, "ld_ubyte");
    do_req(1'b0, 2'b01, 1'b0, 32'h0001_0008, 32'h0, 32'hFFFF_FFF0, "ld_shalf");
    do_req(1'b0, 2'b01, 1'b1, 32'h0001_0008, 32'h0, 32'h0000_FFF0, "ld_uhalf");
    do_req(1'b0, 2'b11, 1'b0, 32'h0001_0000, 32'h0, 32'h4433_2211, "ld_size3");
    do_req(1'b1, 2'b10, 1'b0, 32'h0001_0101, 32'hDEAD_BEEF, 32'h0, "st_word");
    do_req(1'b1, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h1234_A55A, 32'h0, "st_wrap");
    do_req(1'b0, 2'b01, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0000_A55A, "ld_wrap");
    check("st_word mem", {mem[12'h104], mem[12'h103], mem[12'h102], mem[12'h101]},
          32'hDEAD_BEEF);

    // Reset and request together: reset wins.
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00;
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    check("rst_vs_req", {30'd0, req_ready, busy}, 32'd2);

    // Reset in the second XFER cycle of a word store.
    wr0 = wr_seen;
    rsp0 = rsp_seen;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
    req_addr = 32'h0001_0200; req_wdata = 32'h0102_0304;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort byte0", {23'd0, mem_we, mem_wd}, 32'h104);
    @(negedge clk);
    check("abort byte1", {23'd0, mem_we, mem_wd}, 32'h103);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort after", {30'd0, mem_we, req_ready}, 32'd1);
    repeat (6) @(negedge clk);
    check("abort writes", 32'(wr_seen - wr0), 32'd2);
    check("abort no_rsp", 32'(rsp_seen - rsp0), 32'd0);

    do_req(1'b0, 2'b00, 1'b1, 32'h0001_0005, 32'h0, 32'h0000_0080, "ld_after_rst");

    @(negedge clk);
    check("sb empty", 32'(sb_q.size()), 32'd0);
    check("rsp count", 32'(rsp_seen), 32'(n_req));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
